// File: rtl/ps2_letter_decoder.sv
// PS/2 set-2 scan codes -> 5-bit letter codes, with break/extended prefix handling and typematic suppression.
// Push lands 1 cycle after the strobe into a DEPTH-entry FIFO popped by char_ack; a push into a full FIFO is dropped and flagged.
module ps2_letter_decoder #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [7:0]                 ps2_byte,
    input  logic                       ps2_byte_valid,
    input  logic                       char_ack,
    output logic [4:0]                 char,
    output logic                       char_valid,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] L_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BRK,
        S_EXT,
        S_EXT_BRK
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic            w_make;
    logic            w_brk;
    logic [4:0]      w_code;
    logic            w_mapped;
    logic            w_repeat;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_wr;

    logic [7:0]      r_held_code;
    logic            r_held_v;
    logic [4:0]      r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_overflow;

    function automatic logic [4:0] f_lookup(input logic [7:0] b);
        case (b)
            8'h1C: f_lookup = 5'd1;
            8'h32: f_lookup = 5'd2;
            8'h21: f_lookup = 5'd3;
            8'h23: f_lookup = 5'd4;
            8'h24: f_lookup = 5'd5;
            8'h2B: f_lookup = 5'd6;
            8'h34: f_lookup = 5'd7;
            8'h33: f_lookup = 5'd8;
            8'h43: f_lookup = 5'd9;
            8'h3B: f_lookup = 5'd10;
            8'h42: f_lookup = 5'd11;
            8'h4B: f_lookup = 5'd12;
            8'h3A: f_lookup = 5'd13;
            8'h31: f_lookup = 5'd14;
            8'h44: f_lookup = 5'd15;
            8'h4D: f_lookup = 5'd16;
            8'h15: f_lookup = 5'd17;
            8'h2D: f_lookup = 5'd18;
            8'h1B: f_lookup = 5'd19;
            8'h2C: f_lookup = 5'd20;
            8'h3C: f_lookup = 5'd21;
            8'h2A: f_lookup = 5'd22;
            8'h1D: f_lookup = 5'd23;
            8'h22: f_lookup = 5'd24;
            8'h35: f_lookup = 5'd25;
            8'h1A: f_lookup = 5'd26;
            8'h5A: f_lookup = 5'd27;
            8'h66: f_lookup = 5'd28;
            default: f_lookup = 5'd0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_make       = 1'b0;
        w_brk        = 1'b0;
        if (ps2_byte_valid) begin
            case (r_state)
                S_IDLE: begin
                    if (ps2_byte == 8'hE0) begin
                        w_next_state = S_EXT;
                    end else if (ps2_byte == 8'hF0) begin
                        w_next_state = S_BRK;
                    end else begin
                        w_make = 1'b1;
                    end
                end
                S_BRK: begin
                    w_brk        = 1'b1;
                    w_next_state = S_IDLE;
                end
                S_EXT: begin
                    w_next_state = (ps2_byte == 8'hF0) ? S_EXT_BRK : S_IDLE;
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

    assign w_code   = f_lookup(ps2_byte);
    assign w_mapped = (w_code != 5'd0);
    assign w_repeat = r_held_v && (r_held_code == ps2_byte);
    assign w_push   = w_make && w_mapped && !w_repeat;
    assign w_pop    = char_ack && (r_count != '0);
    assign w_full   = (r_count == L_FULL);
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_wr     = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (resetn) begin
            r_held_code <= 8'h00;
            r_held_v    <= 1'b0;
        end else if (w_push) begin
            r_held_code <= ps2_byte;
            r_held_v    <= 1'b1;
        end else if (w_brk && (ps2_byte == r_held_code)) begin
            r_held_v    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_code;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_push && !w_wr) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign char_valid = (r_count != '0);
    assign char       = char_valid ? r_mem[r_rd_ptr] : 5'd0;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
endmodule

// File: tb/tb_ps2_letter_decoder.sv
// Directed bench for ps2_letter_decoder: drives scan-code sequences and checks FIFO head/count/overflow.
module tb_ps2_letter_decoder;
    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] ps2_byte;
    logic       ps2_byte_valid;
    logic       char_ack;
    logic [4:0] char;
    logic       char_valid;
    logic [2:0] fifo_count;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    ps2_letter_decoder #(.DEPTH(4)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .ps2_byte       (ps2_byte),
        .ps2_byte_valid (ps2_byte_valid),
        .char_ack       (char_ack),
        .char           (char),
        .char_valid     (char_valid),
        .fifo_count     (fifo_count),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_ack(input logic [7:0] b, input logic a);
        ps2_byte       = b;
        ps2_byte_valid = 1'b1;
        char_ack       = a;
        tick();
        ps2_byte_valid = 1'b0;
        char_ack       = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        send_ack(b, 1'b0);
    endtask

    task automatic ack();
        char_ack = 1'b1;
        tick();
        char_ack = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b1;
        tick();
        resetn = 1'b0;
    endtask

    initial begin
        resetn         = 1'b1;
        ps2_byte       = 8'h00;
        ps2_byte_valid = 1'b0;
        char_ack       = 1'b0;
        tick();
        tick();
        resetn = 1'b0;

        check("rst_char", int'(char), 0);
        check("rst_valid", int'(char_valid), 0);
        check("rst_count", int'(fifo_count), 0);
        check("rst_ovf", int'(overflow), 0);

        // Single make, 1-cycle latency, then pop to empty
        send(8'h1C);
        check("a_char", int'(char), 1);
        check("a_valid", int'(char_valid), 1);
        check("a_count", int'(fifo_count), 1);
        ack();
        check("a_pop_valid", int'(char_valid), 0);
        check("a_pop_char", int'(char), 0);

        // Release A, then typematic repeat yields one code
        send(8'hF0); send(8'h1C);
        check("brk_nopush", int'(fifo_count), 0);
        send(8'h1C); send(8'h1C); send(8'h1C);
        check("typematic_count", int'(fifo_count), 1);
        send(8'hF0); send(8'h1C); send(8'h1C);
        check("repress_count", int'(fifo_count), 2);
        check("repress_head0", int'(char), 1);
        ack();
        check("repress_head1", int'(char), 1);
        ack();
        check("repress_empty", int'(fifo_count), 0);

        // Extended make/break are discarded, FSM returns to IDLE
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0); send(8'h5A);
        check("ext_nopush", int'(fifo_count), 0);
        send(8'h5A);
        check("enter_char", int'(char), 27);
        check("enter_count", int'(fifo_count), 1);
        ack();

        // Fill, then drop a 5th code while full
        do_reset();
        send(8'h1C); send(8'h32); send(8'h21); send(8'h23);
        check("full_count", int'(fifo_count), 4);
        check("full_ovf0", int'(overflow), 0);
        send(8'h24);
        check("drop_count", int'(fifo_count), 4);
        check("drop_ovf", int'(overflow), 1);
        check("drop_head", int'(char), 1);
        ack();
        check("pop_2", int'(char), 2);
        ack();
        check("pop_3", int'(char), 3);
        ack();
        check("pop_4", int'(char), 4);
        ack();
        check("pop_empty", int'(char_valid), 0);
        check("ovf_sticky", int'(overflow), 1);

        // Push and pop together while full, then while partially full
        do_reset();
        check("rst2_ovf", int'(overflow), 0);
        send(8'h1C); send(8'h32); send(8'h21); send(8'h23);
        send_ack(8'h24, 1'b1);
        check("pp_full_count", int'(fifo_count), 4);
        check("pp_full_ovf", int'(overflow), 0);
        check("pp_full_head", int'(char), 2);
        ack();
        send_ack(8'h2B, 1'b1);
        check("pp_mid_count", int'(fifo_count), 3);
        check("pp_mid_head", int'(char), 4);
        ack();
        check("pp_h5", int'(char), 5);
        ack();
        check("pp_h6", int'(char), 6);
        ack();
        check("pp_empty", int'(fifo_count), 0);

        // Reset discards a pending break prefix; unmapped make leaves held key
        send(8'hF0);
        do_reset();
        send(8'h1C);
        check("rstpfx_char", int'(char), 1);
        check("rstpfx_count", int'(fifo_count), 1);
        send(8'h16);
        check("unmapped_count", int'(fifo_count), 1);
        send(8'h1C);
        check("held_kept", int'(fifo_count), 1);
        ack();
        ack();
        check("ack_empty_count", int'(fifo_count), 0);
        check("ack_empty_valid", int'(char_valid), 0);

        // Rollover: release of old key does not re-arm the still-held new key
        do_reset();
        send(8'h1C); send(8'h1B);
        send(8'hF0); send(8'h1C);
        send(8'h1B);
        check("roll_count", int'(fifo_count), 2);
        check("roll_h0", int'(char), 1);
        ack();
        check("roll_h1", int'(char), 19);
        ack();
        check("roll_empty", int'(char_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
